pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard/stall controller for a classic 5-stage pipeline. Detects taken
//   branches in EX, load-use dependencies between EX and ID, multi-cycle
//   mult/div entering EX, and jumps in ID. It then drives the PC/IF-ID enables,
//   the IF/ID flush and the ID/EX bubble.
//
// Parameters
//   MD_LATENCY      total EX-stage cycles occupied by a mult/div (2..15)
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   id_opcode[5:0]  opcode of the IF/ID instruction
//   id_func[5:0]    func field of the IF/ID instruction
//   id_rs, id_rt    source register fields of the IF/ID instruction
//   ex_mem_read     instruction in EX is a load
//   ex_rt           destination register of the load in EX
//   ex_branch_taken branch in EX resolved taken this cycle
//   pc_write        PC load enable
//   if_id_write     IF/ID load enable
//   if_id_flush     IF/ID loads a NOP this edge
//   id_ex_bubble    ID/EX loads zeroed control this edge
//   busy_state      1 while a mult/div holds the pipeline
//   stall_cycles    saturating count of cycles with pc_write=0
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_func,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        busy_state,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // The mult/div occupies EX for MD_LATENCY cycles. Its first cycle overlaps
    // the RUN cycle in which it issues, so the busy phase lasts MD_LATENCY-1 cycles.
    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  md_cnt, md_cnt_nxt;

    logic ev_br, ev_lu, ev_md, ev_jp;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ev_br = ex_branch_taken;
    // Register 0 is hard-wired zero, so a load into it never creates a hazard.
    assign ev_lu = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign ev_md = (id_opcode == 6'h00) &&
                   ((id_func == 6'h18) || (id_func == 6'h19) ||
                    (id_func == 6'h1A) || (id_func == 6'h1B));
    assign ev_jp = (id_opcode == 6'h02) || (id_opcode == 6'h03);

    assign busy_state = (state == MD_BUSY);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state == RUN) begin
            if (ev_br) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (ev_lu) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (ev_md) begin
                state_nxt  = MD_BUSY;
                md_cnt_nxt = MD_LOAD;
            end else if (ev_jp) begin
                if_id_flush = 1'b1;
            end
        end else begin
            // MD_BUSY: only a taken branch is honoured; it aborts the stall.
            if (ev_br) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_nxt    = RUN;
                md_cnt_nxt   = 4'd0;
            end else begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (md_cnt == 4'd1) begin
                    state_nxt  = RUN;
                    md_cnt_nxt = 4'd0;
                end else begin
                    md_cnt_nxt = md_cnt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            md_cnt       <= 4'd0;
            stall_cycles <= 16'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!pc_write)
                stall_cycles <= sat_inc(stall_cycles);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  id_opcode, id_func;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, ex_branch_taken;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, busy_state;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
        .clk(clk), .reset(reset),
        .id_opcode(id_opcode), .id_func(id_func),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .busy_state(busy_state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {12'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {12'd0, exp});
    endtask

    task automatic idle();
        id_opcode = 6'h00; id_func = 6'h00; id_rs = 5'd0; id_rt = 5'd0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        chk_ctl("reset_ctl", 4'b0011);
        tick();
        chk("reset_busy", {15'd0, busy_state}, 16'd0);
        chk("reset_stall", stall_cycles, 16'd0);

        // First cycle after reset: plain RUN.
        reset = 1'b0; #1;
        chk_ctl("run_idle", 4'b1100);
        tick();
        chk("run_stall0", stall_cycles, 16'd0);

        // Load-use through rs: one bubble, stall count 1.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
        chk_ctl("lu_rs", 4'b0001);
        tick();
        idle(); #1;
        chk_ctl("lu_after", 4'b1100);
        chk("lu_stall", stall_cycles, 16'd1);

        // Load into r0 is never a hazard.
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
        chk_ctl("lu_r0", 4'b1100);
        tick();
        chk("lu_r0_stall", stall_cycles, 16'd1);

        // Load-use through rt.
        idle(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; #1;
        chk_ctl("lu_rt", 4'b0001);
        tick();
        chk("lu_rt_stall", stall_cycles, 16'd2);

        // Mult/div: issue cycle looks normal, then 3 busy cycles.
        idle(); id_func = 6'h1A; #1;
        chk_ctl("md_issue", 4'b1100);
        tick();
        idle(); #1;
        chk("md_busy1", {15'd0, busy_state}, 16'd1);
        chk("md_cnt3", {12'd0, dut.md_cnt}, 16'd3);
        chk_ctl("md_ctl1", 4'b0001);
        tick();
        // A jump in ID is ignored while busy: no flush.
        id_opcode = 6'h02; #1;
        chk("md_busy2", {15'd0, busy_state}, 16'd1);
        chk_ctl("md_jp_ignored", 4'b0001);
        tick();
        // A new mult/div in ID is ignored while busy.
        idle(); id_func = 6'h18; #1;
        chk("md_busy3", {15'd0, busy_state}, 16'd1);
        chk_ctl("md_ctl3", 4'b0001);
        tick();
        idle(); #1;
        chk("md_done_busy", {15'd0, busy_state}, 16'd0);
        chk_ctl("md_done_ctl", 4'b1100);
        chk("md_stall", stall_cycles, 16'd5);

        // BR beats LU.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; #1;
        chk_ctl("br_over_lu", 4'b1111);
        tick();
        chk("br_stall", stall_cycles, 16'd5);

        // LU beats MD: no busy phase follows.
        idle(); ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_func = 6'h18; #1;
        chk_ctl("lu_over_md", 4'b0001);
        tick();
        idle(); #1;
        chk("lu_over_md_busy", {15'd0, busy_state}, 16'd0);
        chk("lu_over_md_stall", stall_cycles, 16'd6);

        // LU beats JP: no flush.
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_opcode = 6'h03; #1;
        chk_ctl("lu_over_jp", 4'b0001);
        tick();
        chk("lu_over_jp_stall", stall_cycles, 16'd7);

        // BR in the 2nd busy cycle aborts the stall.
        idle(); id_func = 6'h19; #1;
        tick();
        idle(); #1;
        chk_ctl("mdbr_busy1", 4'b0001);
        tick();
        ex_branch_taken = 1'b1; #1;
        chk_ctl("mdbr_br", 4'b1111);
        tick();
        idle(); #1;
        chk("mdbr_busy_after", {15'd0, busy_state}, 16'd0);
        chk("mdbr_cnt", {12'd0, dut.md_cnt}, 16'd0);
        chk_ctl("mdbr_run", 4'b1100);
        chk("mdbr_stall", stall_cycles, 16'd8);
        tick();

        // Jumps.
        id_opcode = 6'h02; #1;
        chk_ctl("jp_j", 4'b1110);
        tick();
        id_opcode = 6'h03; #1;
        chk_ctl("jp_jal", 4'b1110);
        tick();
        chk("jp_stall", stall_cycles, 16'd8);

        // Reset in the middle of a busy phase.
        idle(); id_func = 6'h1B; #1;
        tick();
        idle(); #1;
        chk("rst_mid_busy", {15'd0, busy_state}, 16'd1);
        tick();
        chk("rst_mid_stall", stall_cycles, 16'd9);
        reset = 1'b1; #1;
        chk_ctl("rst_mid_ctl", 4'b0011);
        chk("rst_mid_busy_reflect", {15'd0, busy_state}, 16'd1);
        tick();
        chk("rst_mid_state", {15'd0, busy_state}, 16'd0);
        chk("rst_mid_cnt", {12'd0, dut.md_cnt}, 16'd0);
        chk("rst_mid_zero", stall_cycles, 16'd0);
        reset = 1'b0; #1;
        chk_ctl("rst_mid_run", 4'b1100);
        tick();
        chk("rst_mid_stall_after", stall_cycles, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
